// File: rtl/sram_pixel_writer.sv
// Streams 32-bit pixels into an asynchronous 16-bit SRAM as two word writes per pixel.
// Each photo slot occupies 2*size words starting at sel*2*size.
module sram_pixel_writer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_photo_sel,
  input  logic [9:0]        i_col_max,
  input  logic [9:0]        i_row_max,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic [31:0]       i_pix_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  inout  wire  [DATA_W-1:0] io_sram_data,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WR_HI  = 3'd2,
    S_WR_LO  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Pixel handshake: a pixel transfers on a rising edge where i_pix_valid and
  // o_pix_ready are both high; i_pix_data is ignored on every other edge.

  state_t                r_state;
  logic [19:0]           r_size;
  logic [19:0]           r_pix_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic [2*DATA_W-1:0]   r_buf;
  logic                  r_pix_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_we_n;

  logic [19:0]           w_size;
  logic [ADDR_W-1:0]     w_base;
  logic [2*DATA_W-1:0]   w_pix;
  logic [DATA_W-1:0]     w_wdata;

  assign w_size = 20'(i_col_max) * 20'(i_row_max);
  // Multiplying in ADDR_W bits gives the modulo-2^ADDR_W slot base directly.
  assign w_base = (ADDR_W'(i_photo_sel) * ADDR_W'(w_size)) << 1;
  assign w_pix  = (2*DATA_W)'(i_pix_data);

  // Both halves come from the pixel buffer; the select is the registered state,
  // so the bus value is settled for the whole write cycle.
  assign w_wdata = (r_state == S_WR_HI) ? r_buf[2*DATA_W-1:DATA_W] : r_buf[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_pix_cnt   <= '0;
      r_addr      <= '0;
      r_buf       <= '0;
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_size    <= w_size;
            r_addr    <= w_base;
            r_pix_cnt <= '0;
            r_busy    <= 1'b1;
            if (w_size == 20'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_ACCEPT;
              r_pix_ready <= 1'b1;
            end
          end
        end
        S_ACCEPT: begin
          if (i_pix_valid) begin
            r_buf       <= w_pix;
            r_pix_ready <= 1'b0;
            r_we_n      <= 1'b0;
            r_state     <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          r_addr  <= r_addr + 1'b1;
          r_state <= S_WR_LO;
        end
        S_WR_LO: begin
          r_addr    <= r_addr + 1'b1;
          r_pix_cnt <= r_pix_cnt + 20'd1;
          r_we_n    <= 1'b1;
          if (r_pix_cnt == r_size - 20'd1) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_ACCEPT;
            r_pix_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_pix_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_we_n      <= 1'b1;
        end
      endcase
    end
  end

  assign o_pix_ready  = r_pix_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sram_addr  = r_addr;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_oe_n  = 1'b1;
  assign io_sram_data = r_we_n ? {DATA_W{1'bz}} : w_wdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Directed bench for sram_pixel_writer: expected SRAM writes are queued at stimulus time
// and a negedge monitor pops and compares every write the DUT performs.
module tb_sram_pixel_writer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_photo_sel;
  logic [9:0]  i_col_max;
  logic [9:0]  i_row_max;
  logic        i_pix_valid;
  logic        o_pix_ready;
  logic [31:0] i_pix_data;
  logic        o_busy;
  logic        o_done;
  logic [19:0] o_sram_addr;
  logic        o_sram_we_n;
  logic        o_sram_oe_n;
  wire  [15:0] sram_data;
  logic [2:0]  o_dbg_state;

  sram_pixel_writer #(.ADDR_W(20), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_photo_sel  (i_photo_sel),
    .i_col_max    (i_col_max),
    .i_row_max    (i_row_max),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .i_pix_data   (i_pix_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_sram_addr  (o_sram_addr),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .io_sram_data (sram_data),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  logic [35:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [35:0] e;
    if (o_done) done_cnt++;
    if (!o_sram_we_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", o_sram_addr, sram_data);
      end else begin
        e = exp_q.pop_front();
        if ({o_sram_addr, sram_data} !== e) begin
          errors++;
          $display("FAIL sram_write got addr=%0h data=%0h exp addr=%0h data=%0h",
                   o_sram_addr, sram_data, e[35:16], e[15:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(o_pix_ready), 64'd0);
    check({tag, "_busy"},  64'(o_busy),      64'd0);
    check({tag, "_done"},  64'(o_done),      64'd0);
    check({tag, "_we_n"},  64'(o_sram_we_n), 64'd1);
    check({tag, "_oe_n"},  64'(o_sram_oe_n), 64'd1);
    check({tag, "_addr"},  64'(o_sram_addr), 64'd0);
    check({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  task automatic push_pixel(input logic [19:0] a, input logic [31:0] d);
    exp_q.push_back({a, d[31:16]});
    exp_q.push_back({a + 20'd1, d[15:0]});
  endtask

  task automatic start_load(input logic [1:0] sel, input logic [9:0] col, input logic [9:0] row);
    i_photo_sel = sel;
    i_col_max   = col;
    i_row_max   = row;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start   = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_pixel(input logic [31:0] d, input int gap, input logic [19:0] hold_addr,
                            input bit poke);
    bit ok;
    if (gap > 0) begin
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (o_pix_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check("gap_ready_seen", 64'(ok), 64'd1);
      if (poke) begin
        i_start     = 1'b1;
        i_photo_sel = 2'd3;
        i_col_max   = 10'd9;
      end
      for (int g = 0; g < gap; g++) begin
        check("gap_ready", 64'(o_pix_ready), 64'd1);
        check("gap_we_n",  64'(o_sram_we_n), 64'd1);
        check("gap_addr",  64'(o_sram_addr), 64'(hold_addr));
        @(negedge clk);
      end
      i_start = 1'b0;
    end
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (o_pix_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("handshake_ready", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    i_pix_valid = 1'b0;
    i_pix_data  = $urandom;
  endtask

  task automatic wait_done(input int exp_lat);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (o_done) begin
        found = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(found), 64'd1);
    if (found && exp_lat > 0) check("done_latency", 64'(cyc - start_cyc + 1), 64'(exp_lat));
    @(negedge clk);
    check("done_one_cycle", 64'(o_done), 64'd0);
    check("idle_not_busy",  64'(o_busy), 64'd0);
  endtask

  logic [31:0] src_pix [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
  logic [31:0] tgt_pix [4] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};
  logic [31:0] bp_pix  [4] = '{32'h0F0E0D0C, 32'h1B2B3B4B, 32'hCAFEBABE, 32'h12345678};

  initial begin
    logic [3:0] dpat;
    int done_before;
    rst_n       = 1'b1;
    i_start     = 1'b0;
    i_photo_sel = 2'd0;
    i_col_max   = 10'd0;
    i_row_max   = 10'd0;
    i_pix_valid = 1'b0;
    i_pix_data  = 32'h0;

    // asynchronous reset, asserted mid-cycle before any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // source photo 2x2 at slot 0: words 0..7, 13 cycles start-to-done
    start_load(2'd0, 10'd2, 10'd2);
    check("busy_after_start", 64'(o_busy), 64'd1);
    for (int k = 0; k < 4; k++) push_pixel(20'(2 * k), src_pix[k]);
    for (int k = 0; k < 4; k++) send_pixel(src_pix[k], 0, 20'd0, 1'b0);
    wait_done(13);

    // target photo 2x2 at slot 1: base 8, last word 15
    start_load(2'd1, 10'd2, 10'd2);
    for (int k = 0; k < 4; k++) push_pixel(20'(8 + 2 * k), tgt_pix[k]);
    for (int k = 0; k < 4; k++) send_pixel(tgt_pix[k], 0, 20'd0, 1'b0);
    wait_done(13);

    // output slot 2 (base 16) with 5-cycle valid gaps and a start pulse while busy
    start_load(2'd2, 10'd2, 10'd2);
    for (int k = 0; k < 4; k++) push_pixel(20'(16 + 2 * k), bp_pix[k]);
    send_pixel(bp_pix[0], 0, 20'd0,  1'b0);
    send_pixel(bp_pix[1], 5, 20'd18, 1'b1);
    send_pixel(bp_pix[2], 5, 20'd20, 1'b0);
    send_pixel(bp_pix[3], 0, 20'd0,  1'b0);
    wait_done(0);

    // zero-size load (col=0) with start held: done at once, then a fresh load restarts
    i_photo_sel = 2'd1;
    i_col_max   = 10'd0;
    i_row_max   = 10'd4;
    i_start     = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); dpat[0] = o_done;
    @(posedge clk); #1;
    @(negedge clk); dpat[1] = o_done;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk); dpat[2] = o_done;
    @(posedge clk); #1;
    @(negedge clk); dpat[3] = o_done;
    check("zero_size_done_pattern", 64'(dpat), 64'b0101);

    // 4x1 load with reset during the third write: no further writes, no done
    start_load(2'd0, 10'd4, 10'd1);
    push_pixel(20'd0, 32'hAAAA5555);
    exp_q.push_back({20'd2, 16'h1357});
    send_pixel(32'hAAAA5555, 0, 20'd0, 1'b0);
    send_pixel(32'h13572468, 0, 20'd0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    check("mid_writes_drained", 64'(exp_q.size()), 64'd0);
    done_before = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt), 64'(done_before));

    // new load after the abandoned one starts again at base 0
    start_load(2'd0, 10'd1, 10'd1);
    push_pixel(20'd0, 32'h600DF00D);
    send_pixel(32'h600DF00D, 0, 20'd0, 1'b0);
    wait_done(4);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("total_done_pulses", 64'(done_cnt), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_pixel_writer.md
SRAM_PIXEL_WRITER -- requirements
Module: sram_pixel_writer

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL set the SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the SRAM data width; the pixel word is 2*DATA_W bits.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_start  input  1  SHALL request a one-photo load; sampled only in IDLE.
REQ-006 i_photo_sel  input  2  SHALL give the photo slot index: 0 source, 1 target, 2 output, 3 spare.
REQ-007 i_col_max  input  10  SHALL give the photo width in pixels; latched at start.
REQ-008 i_row_max  input  10  SHALL give the photo height in pixels; latched at start.
REQ-009 i_pix_valid  input  1  SHALL qualify i_pix_data.
REQ-010 o_pix_ready  output  1  SHALL indicate the block accepts a pixel this cycle.
REQ-011 i_pix_data  input  32  SHALL carry the pixel as {R[31:24], G[23:16], B[15:8], aux[7:0]}.
REQ-012 o_busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 o_done  output  1  SHALL pulse for exactly one cycle when a photo load completes.
REQ-014 o_sram_addr  output  ADDR_W  SHALL carry the SRAM word address.
REQ-015 o_sram_we_n  output  1  SHALL be the SRAM write enable, active-low.
REQ-016 o_sram_oe_n  output  1  SHALL be the SRAM output enable, active-low; the block SHALL hold it at 1 at all times.
REQ-017 io_sram_data  inout  DATA_W  SHALL be driven with write data while o_sram_we_n=0, and SHALL be high-Z otherwise.

Function
REQ-018 FSM states SHALL be IDLE, ACCEPT, WR_HI, WR_LO, DONE.
REQ-019 IDLE + i_start: latch size = i_col_max*i_row_max (20 bit), base = (i_photo_sel*2*size) mod 2^ADDR_W, addr = base, pix_cnt = 0; then go to ACCEPT, or to DONE if size == 0.
REQ-020 ACCEPT: o_pix_ready=1. On i_pix_valid=1, latch i_pix_data into a 32-bit buffer and go to WR_HI. Without valid, remain in ACCEPT with no SRAM activity.
REQ-021 o_pix_ready SHALL be 0 in every state except ACCEPT; i_pix_data SHALL be sampled only on the valid&ready cycle.
REQ-022 WR_HI: o_sram_we_n=0, o_sram_addr=addr, io_sram_data=buffer[31:16]; addr increments by 1; go to WR_LO.
REQ-023 WR_LO: o_sram_we_n=0, o_sram_addr=addr, io_sram_data=buffer[15:0]; addr increments by 1; pix_cnt increments by 1; go to DONE if the old pix_cnt == size-1, else go to ACCEPT.
REQ-024 Throughput SHALL be at most one pixel per 3 cycles; pixel k SHALL occupy addresses base+2k (high word) and base+2k+1 (low word).
REQ-025 Address and data SHALL be driven from registers and be stable for the entire cycle in which o_sram_we_n=0.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error flag.
REQ-027 DONE: o_done=1 for one cycle, then go to IDLE.
REQ-028 i_start asserted in any state other than IDLE SHALL be ignored, with no effect on latched size, base or address.
REQ-029 The block SHALL perform no write without a completed pixel handshake.
REQ-030 A held i_start on the cycle the FSM returns to IDLE SHALL start a new load with fresh latched values.

Reset
REQ-031 rst_n low SHALL force state=IDLE, addr=0, pix_cnt=0, size=0, base=0, buffer=0 immediately.
REQ-032 rst_n low SHALL force the outputs o_pix_ready=0, o_busy=0, o_done=0, o_sram_we_n=1, o_sram_oe_n=1, o_sram_addr=0, io_sram_data=Z.
REQ-033 Reset asserted mid-load SHALL abandon the photo with no o_done, and SHALL complete no further write after reset assertion.

Verification
REQ-034 Reset check: assert rst_n=0 mid-cycle -> all outputs take their REQ-032 values asynchronously.
REQ-035 Source load: 2x2, sel=0, pixels 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00, valid always high -> writes 0x1122@0, 0x3344@1 ... 0xFF00@7 in order; o_done one cycle after the last WR_LO; total 13 cycles from start.
REQ-036 Target load: 2x2, sel=1 -> the first write goes to address 8 and the last to address 15.
REQ-037 Backpressure: valid low for 5 cycles between pixels -> o_pix_ready stays 1, o_sram_we_n stays 1, no address change.
REQ-038 Start while busy is ignored; a 0x4 size load (col=0) -> o_done is high in the cycle after start with no writes.
REQ-039 Reset after the 3rd write of a 4x1 load -> no further write, no o_done; a new start restarts at base.
